// File: rtl/fsm_sched_if.sv
// fsm_sched_if: requester and detector bus of the round-robin serial job scheduler.
interface fsm_sched_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic [3:0]          req;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          gnt;
  logic                busy;
  logic                done;
  logic [1:0]          done_id;
  logic [CNT_W-1:0]    hit_count;
  logic                det_in;
  logic                det_rst_n;
  logic                det_out;
  modport master (
    output req, req_data, det_out,
    input  gnt, busy, done, done_id, hit_count, det_in, det_rst_n
  );
  modport slave (
    input  req, req_data, det_out,
    output gnt, busy, done, done_id, hit_count, det_in, det_rst_n
  );
endinterface

// File: rtl/fsm_sched.sv
// fsm_sched: round-robin scheduler serialising one requester word at a time through a shared detector.
module fsm_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  fsm_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d, id_q, id_d, done_id_q, done_id_d, win;
  logic [3:0]        gnt_q, gnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  bit_q, bit_d, cnt_q, cnt_d, hit_q, hit_d, cnt_inc;
  logic              det_rst_n_q, det_rst_n_d;
  // Scan downward so the requester closest above ptr overwrites the rest.
  always_comb begin
    win = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (bus.req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    gnt_d     = gnt_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    done_id_d = done_id_q;
    cnt_inc   = cnt_q + CNT_W'(bus.det_out);
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = CLR;
        gnt_d   = 4'b0001 << win;
        sh_d    = bus.req_data[win*DATA_W +: DATA_W];
        id_d    = win;
        cnt_d   = '0;
      end
      CLR: begin
        state_d = SHIFT;
        bit_d   = '0;
      end
      // The detector output lags one bit, so the first shift cycle has nothing to sample.
      SHIFT: begin
        sh_d    = sh_q << 1;
        bit_d   = bit_q + 1'b1;
        cnt_d   = (bit_q != '0) ? cnt_inc : cnt_q;
        state_d = (bit_q == CNT_W'(DATA_W-1)) ? DRAIN : SHIFT;
      end
      DRAIN: begin
        state_d   = DONE;
        cnt_d     = cnt_inc;
        hit_d     = cnt_inc;
        done_id_d = id_q;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = id_q + 1'b1;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    det_rst_n_d = (state_d != CLR);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      sh_q        <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      hit_q       <= '0;
      done_id_q   <= '0;
      det_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      done_id_q   <= done_id_d;
      det_rst_n_q <= det_rst_n_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.done_id   = done_id_q;
  assign bus.hit_count = hit_q;
  assign bus.det_in    = (state_q == SHIFT) && sh_q[DATA_W-1];
  assign bus.det_rst_n = det_rst_n_q;
endmodule

// File: tb/tb_fsm_sched.sv
// tb_fsm_sched: directed tests of fsm_sched against a behavioural 3-state detector (A=0, B=1, C=2, Out1 high in C).
module tb_fsm_sched;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int passed = 0;
  int total = 0;
  logic [1:0] det_s = 2'd0;
  logic [7:0] obs_bits;
  logic [3:0] obs_gnt, obs_cnt;
  logic [1:0] obs_id;
  logic [1:0] st_seq [8];
  logic [1:0] exp_st [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
  int done_cyc, rstn_low;

  fsm_sched_if #(.DATA_W(8), .CNT_W(4)) bus ();
  fsm_sched #(.DATA_W(8), .CNT_W(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // A -1-> B, B -0-> C, C -1-> A; otherwise stay.
  always @(posedge CLK or negedge bus.det_rst_n)
    if (!bus.det_rst_n) det_s <= 2'd0;
    else det_s <= (det_s == 2'd0) ? (bus.det_in ? 2'd1 : 2'd0) :
                  (det_s == 2'd1) ? (bus.det_in ? 2'd1 : 2'd2) :
                                    (bus.det_in ? 2'd0 : 2'd2);
  assign bus.det_out = (det_s == 2'd2);

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Cycle 1 is the CLR cycle; ends one cycle after done, back in IDLE.
  task automatic run_job(input logic [3:0] r, input logic [31:0] d, input bit drop);
    bus.req = r; bus.req_data = d;
    obs_bits = '0; obs_gnt = '0; obs_id = 2'bxx; obs_cnt = 4'bxxxx;
    done_cyc = -1; rstn_low = 0;
    for (int i = 0; i < 8; i++) st_seq[i] = 2'bxx;
    for (int c = 1; c <= 14 && done_cyc < 0; c++) begin
      tick();
      if (c == 1) obs_gnt = bus.gnt;
      if (drop && c == 4) begin bus.req = '0; bus.req_data = ~d; end
      if (!bus.det_rst_n) rstn_low++;
      if (c >= 2 && c <= 9) obs_bits[9-c] = bus.det_in;
      if (c >= 3 && c <= 10) st_seq[c-3] = det_s;
      if (bus.done) begin done_cyc = c; obs_id = bus.done_id; obs_cnt = bus.hit_count; end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_data = '0; RST = 1'b0;
    tick(); tick();
    total++; if (bus.gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    total++; if ({bus.done_id, bus.hit_count} !== 6'b0) $display("FAIL reset_id_cnt: got %b want 000000", {bus.done_id, bus.hit_count}); else passed++;
    total++; if ({bus.det_in, bus.det_rst_n} !== 2'b00) $display("FAIL reset_det: got %b want 00", {bus.det_in, bus.det_rst_n}); else passed++;
    RST = 1'b1;
    tick(); tick();
    total++; if ({bus.busy, bus.gnt} !== 5'b0) $display("FAIL idle_no_req: got %b want 00000", {bus.busy, bus.gnt}); else passed++;
    total++; if (bus.det_rst_n !== 1'b1) $display("FAIL idle_det_rst_n: got %b want 1", bus.det_rst_n); else passed++;
  endtask

  task automatic test_single();
    run_job(4'b0001, 32'h0000_0080, 1'b0);
    total++; if (obs_gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", obs_gnt); else passed++;
    total++; if (obs_bits !== 8'h80) $display("FAIL single_det_in: got %h want 80", obs_bits); else passed++;
    total++; if (done_cyc !== 11) $display("FAIL single_latency: got %0d want 11", done_cyc); else passed++;
    total++; if (obs_id !== 2'd0) $display("FAIL single_done_id: got %0d want 0", obs_id); else passed++;
    total++; if (obs_cnt !== 4'd7) $display("FAIL single_hits: got %0d want 7", obs_cnt); else passed++;
    total++; if (rstn_low !== 1) $display("FAIL single_clr_len: got %0d want 1", rstn_low); else passed++;
    total++; if ({bus.busy, bus.gnt, bus.done} !== 6'b0) $display("FAIL single_back_idle: got %b want 000000", {bus.busy, bus.gnt, bus.done}); else passed++;
    total++; if ({bus.done_id, bus.hit_count} !== {2'd0, 4'd7}) $display("FAIL single_hold: got %h want 07", {bus.done_id, bus.hit_count}); else passed++;
  endtask

  task automatic test_pattern();
    run_job(4'b0100, 32'h0065_0000, 1'b0);
    total++; if (obs_gnt !== 4'b0100) $display("FAIL pat_gnt: got %b want 0100", obs_gnt); else passed++;
    total++; if (obs_bits !== 8'h65) $display("FAIL pat_det_in: got %h want 65", obs_bits); else passed++;
    for (int i = 1; i < 8; i++) begin
      total++; if (st_seq[i] !== exp_st[i]) $display("FAIL pat_state_bit%0d: got %0d want %0d", i+1, st_seq[i], exp_st[i]); else passed++;
    end
    total++; if (obs_id !== 2'd2) $display("FAIL pat_done_id: got %0d want 2", obs_id); else passed++;
    total++; if (obs_cnt !== 4'd2) $display("FAIL pat_hits: got %0d want 2", obs_cnt); else passed++;
  endtask

  task automatic test_extremes();
    run_job(4'b0010, 32'h0000_0000, 1'b0);
    total++; if (obs_cnt !== 4'd0) $display("FAIL zero_hits: got %0d want 0", obs_cnt); else passed++;
    total++; if (obs_id !== 2'd1) $display("FAIL zero_done_id: got %0d want 1", obs_id); else passed++;
    total++; if (rstn_low !== 1) $display("FAIL zero_clr_len: got %0d want 1", rstn_low); else passed++;
    run_job(4'b1000, 32'hFF00_0000, 1'b0);
    total++; if (obs_cnt !== 4'd0) $display("FAIL ones_hits: got %0d want 0", obs_cnt); else passed++;
    total++; if (obs_bits !== 8'hFF) $display("FAIL ones_det_in: got %h want ff", obs_bits); else passed++;
    total++; if (rstn_low !== 1) $display("FAIL ones_clr_len: got %0d want 1", rstn_low); else passed++;
  endtask

  task automatic test_round_robin();
    int ids[$];
    int cyc[$];
    int bad = 0;
    RST = 1'b0; tick(); RST = 1'b1;
    bus.req = 4'hF; bus.req_data = 32'h8080_8080;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.busy ? !$onehot(bus.gnt) : (bus.gnt != 4'b0)) bad++;
      if (bus.done) begin ids.push_back(int'(bus.done_id)); cyc.push_back(c); end
    end
    bus.req = '0;
    for (int c = 0; c < 15 && bus.busy; c++) tick();
    total++; if (ids.size() !== 5) $display("FAIL rr_done_count: got %0d want 5", ids.size()); else passed++;
    for (int i = 0; i < ids.size(); i++) begin
      total++; if (ids[i] !== i % 4) $display("FAIL rr_id%0d: got %0d want %0d", i, ids[i], i % 4); else passed++;
    end
    for (int i = 1; i < cyc.size(); i++) begin
      total++; if (cyc[i] - cyc[i-1] !== 12) $display("FAIL rr_gap%0d: got %0d want 12", i, cyc[i] - cyc[i-1]); else passed++;
    end
    total++; if (bad !== 0) $display("FAIL rr_onehot: got %0d bad cycles want 0", bad); else passed++;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    run_job(4'b0100, 32'h0080_0000, 1'b0);
    bus.req = 4'b0100;
    for (int c = 0; c < 5; c++) tick();
    total++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bus.busy); else passed++;
    RST = 1'b0;
    #2;
    total++; if ({bus.busy, bus.gnt} !== 5'b0) $display("FAIL mid_async_gnt_busy: got %b want 00000", {bus.busy, bus.gnt}); else passed++;
    total++; if ({bus.done_id, bus.hit_count} !== 6'b0) $display("FAIL mid_async_id_cnt: got %b want 000000", {bus.done_id, bus.hit_count}); else passed++;
    total++; if ({bus.done, bus.det_in, bus.det_rst_n} !== 3'b0) $display("FAIL mid_async_det: got %b want 000", {bus.done, bus.det_in, bus.det_rst_n}); else passed++;
    bus.req = 4'b1000;
    tick(); if (bus.done) dones++;
    bus.req = 4'b1001;
    tick(); if (bus.done) dones++;
    RST = 1'b1;
    tick();
    total++; if (dones !== 0) $display("FAIL mid_no_done: got %0d want 0", dones); else passed++;
    total++; if (bus.gnt !== 4'b0001) $display("FAIL mid_first_gnt: got %b want 0001", bus.gnt); else passed++;
    bus.req = '0;
    done_cyc = -1;
    for (int c = 2; c <= 14 && done_cyc < 0; c++) begin
      tick();
      if (bus.done) begin done_cyc = c; obs_id = bus.done_id; end
    end
    tick();
    total++; if (done_cyc !== 11) $display("FAIL mid_after_latency: got %0d want 11", done_cyc); else passed++;
    total++; if (obs_id !== 2'd0) $display("FAIL mid_after_id: got %0d want 0", obs_id); else passed++;
  endtask

  task automatic test_drop_req();
    run_job(4'b0010, 32'h0000_6500, 1'b1);
    total++; if (done_cyc !== 11) $display("FAIL drop_latency: got %0d want 11", done_cyc); else passed++;
    total++; if (obs_id !== 2'd1) $display("FAIL drop_done_id: got %0d want 1", obs_id); else passed++;
    total++; if (obs_cnt !== 4'd2) $display("FAIL drop_hits: got %0d want 2", obs_cnt); else passed++;
    total++; if (obs_bits !== 8'h65) $display("FAIL drop_det_in: got %h want 65", obs_bits); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_pattern();
    test_extremes();
    test_round_robin();
    test_reset_mid();
    test_drop_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fsm_sched.md
FSM_SCHED -- requirements
Module: fsm_sched

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, number of serial bits per job (>=2).
REQ-002 The block SHALL have parameter CNT_W, default 4, equal to ceil(log2(DATA_W+1)), the hit counter width.
REQ-003 The block SHALL have port CLK  input  1  single system clock, all state on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req  input  4  level request, one bit per requester 0..3.
REQ-006 The block SHALL have port req_data  input  4*DATA_W  job word, requester i on bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port gnt  output  4  one-hot grant, all-zero when idle.
REQ-008 The block SHALL have port busy  output  1  high while a job is in progress (any state except IDLE).
REQ-009 The block SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-010 The block SHALL have port done_id  output  2  index of the completed requester, valid with done and held until the next done.
REQ-011 The block SHALL have port hit_count  output  CNT_W  number of detector-high samples in the last job, held until the next done.
REQ-012 The block SHALL have port det_in  output  1  serial bit to the shared 3-state detector's In1.
REQ-013 The block SHALL have port det_rst_n  output  1  registered active-low reset to the detector's RST.
REQ-014 The block SHALL have port det_out  input  1  the detector's Moore output Out1, which reflects the bit presented one cycle earlier.

Function
REQ-015 The block SHALL implement states IDLE, CLR, SHIFT, DRAIN and DONE, and SHALL process one job at a time.
REQ-016 In IDLE with any req bit set, the block SHALL select the requester by round-robin, searching from pointer ptr upward modulo 4, and SHALL go to CLR at the next edge.
REQ-017 On that edge, the block SHALL set gnt to the one-hot winner, latch the winner's req_data slice into a shift register, latch the winner's index, and clear the hit counter.
REQ-018 In IDLE with req==0, the block SHALL remain in IDLE with gnt==0.
REQ-019 CLR SHALL last exactly 1 cycle with det_rst_n=0, so the detector returns to its initial state; det_rst_n SHALL be 1 in every other state.
REQ-020 SHIFT SHALL last exactly DATA_W cycles, driving det_in with the shift register MSB first, one bit per cycle.
REQ-021 In SHIFT cycles 2..DATA_W and in the single DRAIN cycle, the block SHALL increment the hit counter when det_out==1, giving DATA_W samples, each following one bit.
REQ-022 The block SHALL ignore det_out in the first SHIFT cycle.
REQ-023 det_in SHALL be 0 in IDLE, CLR, DRAIN and DONE.
REQ-024 In DONE, lasting 1 cycle, the block SHALL assert done, present done_id and hit_count, and set ptr = (winner+1) mod 4; the next state SHALL be IDLE.
REQ-025 gnt SHALL stay constant from CLR through DONE and SHALL clear on entry to IDLE.
REQ-026 Latency SHALL be fixed: with req sampled in IDLE at cycle 0, done SHALL assert in cycle DATA_W+3 (cycle 11 for DATA_W=8).
REQ-027 The next grant SHALL occur no earlier than the cycle after DONE.
REQ-028 Changes to req or req_data after grant SHALL not affect the running job; a requester that drops req mid-job SHALL still receive done.
REQ-029 A requester holding req continuously SHALL be re-served only after every other asserted requester has been served once.
REQ-030 hit_count SHALL never exceed DATA_W, and no counter wrap SHALL be possible.

Reset
REQ-031 RST low SHALL, asynchronously, force state IDLE, ptr=0, gnt=0, busy=0, done=0, done_id=0, hit_count=0, det_in=0, det_rst_n=0, and clear the shift register.
REQ-032 Reset SHALL abort any job in progress with no done pulse.
REQ-033 After RST rises, the first arbitration SHALL start at requester 0.

Verification
REQ-034 The bench SHALL cover: req=0001, byte0=0x80 -> gnt=0001, det_in 1,0,0,0,0,0,0,0; done at cycle 11, done_id=0, hit_count=7.
REQ-035 The bench SHALL cover: req=0100, byte2=0x65 -> detector states B,B,C,C,A,A,B after bits 2..8; done_id=2, hit_count=2.
REQ-036 The bench SHALL cover: byte=0x00 -> hit_count=0; byte=0xFF -> hit_count=0; det_rst_n low exactly one cycle per job.
REQ-037 The bench SHALL cover: req=1111 held continuously -> done_id sequence 0,1,2,3,0; gnt always one-hot; consecutive done pulses 12 cycles apart.
REQ-038 The bench SHALL cover: RST pulsed low mid-SHIFT -> all outputs at reset values immediately, no done; with req=1000 then 0001 asserted after release, the grant goes to requester 0 first.
REQ-039 The bench SHALL cover: requester drops req and changes req_data during SHIFT -> done still asserted for that requester, with hit_count computed from the latched word.
